// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a valid/ready byte input and a one-entry holding register.
// Build option: define UART_TX_PARITY_EN to append an even-parity bit after D7.
module uart_tx #(
    parameter int unsigned CLK_RATE  = 100_000_000,
    parameter int unsigned BAUD_RATE = 1_000_000,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       areset,
    input  logic [7:0] data,
    input  logic       data_val,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BAUD = int'(CLK_RATE / BAUD_RATE);
    localparam int unsigned CntW          = $clog2(CLKS_PER_BAUD + 1);
    localparam logic [CntW-1:0] BaudLast  = CntW'(CLKS_PER_BAUD);
    localparam logic [CntW-1:0] BaudOne   = CntW'(1);

    if (CLKS_PER_BAUD < 2) begin : g_bad_baud
        $error("uart_tx: CLK_RATE / BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e          state_q, state_d;
    logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            stop_cnt_q, stop_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_val_q, hold_val_d;
    logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic       handshake;
    logic       baud_end;
    logic       stop_last;
    logic       frame_end;
    logic       load;
    logic [7:0] load_byte;

    assign handshake = data_val && ready;
    assign baud_end  = (baud_cnt_q == BaudLast);
    assign stop_last = (STOP_BITS == 1) || stop_cnt_q;
    assign frame_end = (state_q == StStop) && baud_end && stop_last;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_val_d = hold_val_q;
        load       = 1'b0;
        load_byte  = data;

        if (state_q != StIdle) begin
            baud_cnt_d = baud_end ? BaudOne : baud_cnt_q + BaudOne;
        end

        unique case (state_q)
            StIdle: begin
                if (handshake) load = 1'b1;
            end
            StStart: begin
                if (baud_end) begin
                    state_d   = StData;
                    bit_cnt_d = 3'd0;
                end
            end
            StData: begin
                if (baud_end) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                        stop_cnt_d = 1'b0;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_end) begin
                    state_d    = StStop;
                    stop_cnt_d = 1'b0;
                end
            end
`endif
            StStop: begin
                if (baud_end) begin
                    if (!stop_last) begin
                        stop_cnt_d = 1'b1;
                    end else if (hold_val_q) begin
                        load       = 1'b1;
                        load_byte  = hold_q;
                        hold_val_d = 1'b0;
                    end else if (handshake) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A new frame starts on the next cycle with no idle gap.
        if (load) begin
            state_d    = StStart;
            shift_d    = load_byte;
            baud_cnt_d = BaudOne;
        end

        if (handshake && state_q != StIdle && !frame_end) begin
            hold_d     = data;
            hold_val_d = 1'b1;
        end

        if (state_d == StIdle) baud_cnt_d = '0;

`ifdef UART_TX_PARITY_EN
        parity_d = load ? ^load_byte : parity_q;
`endif

        // tx is registered, so it is decoded from the next state.
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            shift_q    <= 8'h00;
            hold_q     <= 8'h00;
            hold_val_q <= 1'b0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_val_q <= hold_val_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign ready = ~hold_val_q;
    assign tx    = tx_q;
    assign busy  = (state_q != StIdle) || hold_val_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx; a line monitor decodes frames and pops a byte scoreboard.
module tb_uart_tx;

    localparam int unsigned CLK_RATE  = 10_500_000;
    localparam int unsigned BAUD_RATE = 1_000_000;
    localparam int unsigned STOP_BITS = 1;
    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME = (9 + PAR_BITS + STOP_BITS) * CPB;

    logic       clk = 1'b0;
    logic       areset = 1'b0;
    logic [7:0] data = 8'h00;
    logic       data_val = 1'b0;
    logic       ready;
    logic       tx;
    logic       busy;

    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    bit   mon_en = 1'b0;
    logic [7:0] exp_q[$];
    int   start_q[$];

    uart_tx #(
        .CLK_RATE (CLK_RATE),
        .BAUD_RATE(BAUD_RATE),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clk     (clk),
        .areset  (areset),
        .data    (data),
        .data_val(data_val),
        .ready   (ready),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level k cycles after the handshake cycle (k = 1 is the first start cycle).
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        int idx;
        idx = (k - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR_BITS == 1 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    // Called at a negedge; leaves data_val low at a negedge after the handshake.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        data = b;
        data_val = 1'b1;
        while (ready !== 1'b1 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_wait", (n < 4 * FRAME), 1);
        exp_q.push_back(b);
        @(negedge clk);
        data_val = 1'b0;
    endtask

    // Sends one byte from an idle line and checks the whole waveform cycle by cycle.
    task automatic send_and_watch(input string tag, input logic [7:0] b);
        int errs;
        int rdy_errs;
        logic busy_last;
        errs = 0;
        rdy_errs = 0;
        check({tag, "_ready_pre"}, ready, 1);
        send(b);
        for (int k = 1; k <= FRAME; k++) begin
            if (tx !== exp_bit(b, k)) errs++;
            if (ready !== 1'b1) rdy_errs++;
            busy_last = busy;
            @(negedge clk);
        end
        check({tag, "_wave"}, errs, 0);
        check({tag, "_ready_held"}, rdy_errs, 0);
        check({tag, "_busy_last_cycle"}, busy_last, 1);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_tx_after"}, tx, 1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < FRAME * (exp_q.size() + 3)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin : monitor
        logic [7:0] b;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (mon_en && !areset && tx === 1'b0) begin
                start_q.push_back(cycle);
                repeat (CPB / 2) @(negedge clk);
                check("mon_start", tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                check("mon_parity", tx, ^b);
`endif
                for (int s = 0; s < STOP_BITS; s++) begin
                    repeat (CPB) @(negedge clk);
                    check("mon_stop", tx, 1);
                end
                check("mon_expected_frame", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    check("mon_byte", b, want);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int errs;
        int n;
        int gaps;

        // Reset and idle line
        #2 areset = 1'b1;
        #1;
        check("reset_tx", tx, 1);
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        repeat (3) @(negedge clk);
        areset = 1'b0;
        errs = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) errs++;
        end
        check("idle_500", errs, 0);

        // Single frame, exact timing
        mon_en = 1'b1;
        send_and_watch("t2_55", 8'h55);
        drain("t2");

        // Second byte waits in the holding register, frames abut
        start_q.delete();
        data = 8'hA3;
        data_val = 1'b1;
        exp_q.push_back(8'hA3);
        @(negedge clk);
        check("t3_ready_after_direct", ready, 1);
        data = 8'h0F;
        exp_q.push_back(8'h0F);
        @(negedge clk);
        check("t3_ready_held", ready, 0);
        check("t3_busy", busy, 1);
        data = 8'hEE;
        n = 0;
        while (ready !== 1'b1 && n < FRAME + 10) begin
            @(negedge clk);
            n++;
        end
        data_val = 1'b0;
        check("t3_ready_return", n, FRAME - 1);
        drain("t3");
        check("t3_frames", start_q.size(), 2);
        if (start_q.size() == 2) check("t3_start_gap", start_q[1] - start_q[0], FRAME);

        // data_val held high with a constant byte: one frame per handshake
        start_q.delete();
        data = 8'h3C;
        data_val = 1'b1;
        n = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            if (ready === 1'b1) begin
                exp_q.push_back(8'h3C);
                n++;
            end
            @(negedge clk);
        end
        data_val = 1'b0;
        check("t3b_handshakes", n, 4);
        drain("t3b");
        check("t3b_frames", start_q.size(), 4);

        // Asynchronous reset in the middle of a frame with a byte held
        mon_en = 1'b0;
        data = 8'hFF;
        data_val = 1'b1;
        @(negedge clk);
        data = 8'h00;
        @(negedge clk);
        data_val = 1'b0;
        check("t4_ready_held", ready, 0);
        repeat (43) @(negedge clk);
        areset = 1'b1;
        #1;
        check("t4_async_tx", tx, 1);
        check("t4_async_ready", ready, 1);
        check("t4_async_busy", busy, 0);
        @(negedge clk);
        areset = 1'b0;
        errs = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        check("t4_no_resume", errs, 0);
        mon_en = 1'b1;
        send_and_watch("t4_81", 8'h81);
        drain("t4");

        // 256 bytes back to back through the line monitor
        start_q.delete();
        for (int i = 0; i < 256; i++) send(8'(i));
        drain("t5");
        check("t5_frames", start_q.size(), 256);
        gaps = 0;
        for (int i = 1; i < start_q.size(); i++) begin
            if (start_q[i] - start_q[i-1] != FRAME) gaps++;
        end
        check("t5_no_gaps", gaps, 0);

        // Parity-sensitive bytes (frame length and parity bit follow the build option)
        send_and_watch("t6_07", 8'h07);
        drain("t6a");
        send_and_watch("t6_03", 8'h03);
        drain("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
